// File: rtl/uart_aes_pkg.sv
// Shared constants and state encodings for the UART/AES command sequencer.
package uart_aes_pkg;

  localparam logic [7:0] CMD_KEY  = 8'h4B;
  localparam logic [7:0] CMD_PT   = 8'h50;
  localparam logic [7:0] CMD_STAT = 8'h53;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  localparam int unsigned BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRxKey,
    StRxPt,
    StKeyLoad,
    StAesStart,
    StAesWait,
    StTx
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxLoad,
    TxReq,
    TxWait
  } tx_state_e;

endpackage

// File: rtl/uart_aes_ctrl_tx_seq.sv
// UART reply sequencer: sends one byte or a 16-byte block over the
// tx_data_en / tx_busy handshake, MSB byte first.
module uart_tx_seq
  import uart_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         load_block,
  input  logic [7:0]   load_byte,
  input  logic [127:0] load_data,
  output logic         done,
  input  logic         tx_busy,
  output logic         tx_data_en,
  output logic [7:0]   tx_data
);

  tx_state_e    state_q, state_d;
  logic [127:0] sreg_q;
  logic [4:0]   cnt_q;
  logic         en_q;
  logic [7:0]   data_q;

  assign tx_data_en = en_q;
  assign tx_data    = data_q;

  // Next-state decode; done pulses as the last byte's transmission ends.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      TxIdle: if (load) state_d = TxLoad;
      TxLoad: state_d = TxReq;
      TxReq:  if (tx_busy) state_d = TxWait;
      TxWait: begin
        if (!tx_busy) begin
          if (cnt_q == 5'd1) begin
            done    = 1'b1;
            state_d = TxIdle;
          end else begin
            state_d = TxLoad;
          end
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // State, shift register and registered UART pins (glitch-free request edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TxIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        TxIdle: begin
          if (load) begin
            sreg_q <= load_block ? load_data : {load_byte, 120'h0};
            cnt_q  <= load_block ? 5'(BLOCK_BYTES) : 5'd1;
          end
        end
        TxLoad: begin
          data_q <= sreg_q[127:120];
          en_q   <= 1'b1;
        end
        TxReq: if (tx_busy) en_q <= 1'b0;
        TxWait: begin
          if (!tx_busy) begin
            cnt_q  <= cnt_q - 5'd1;
            sreg_q <= {sreg_q[119:0], 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_aes_ctrl.sv
// Command sequencer between the UART byte transceiver and the AES core:
// parses K/P/S frames, loads key/plaintext, runs the core, replies over UART.
module uart_aes_ctrl
  import uart_aes_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT_CYC = 5000000,
  parameter int unsigned TO_W           = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_data_en,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_data_en,
  output logic [7:0]   tx_data,
  output logic [127:0] aes_key,
  output logic         aes_key_load,
  output logic [127:0] aes_din,
  output logic         aes_start,
  input  logic         aes_busy,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  output logic         ctrl_busy,
  output logic         err_flag
);

  ctrl_state_e    state_q, state_d;
  logic [127:0]   key_q, din_q;
  logic [3:0]     byte_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic           err_ov_q, err_to_q, start_q;
  logic           in_rx, to_hit, stat_clr, overrun;
  logic           tx_load, tx_block, tx_done;
  logic [7:0]     tx_byte;

  assign in_rx    = (state_q == StRxKey) || (state_q == StRxPt);
  assign to_hit   = in_rx && !rx_data_en && (to_cnt_q == TO_W'(RX_TIMEOUT_CYC - 1));
  assign stat_clr = (state_q == StIdle) && rx_data_en && (rx_data == CMD_STAT);
  assign overrun  = rx_data_en && !in_rx && (state_q != StIdle);

  assign aes_key      = key_q;
  assign aes_din      = din_q;
  assign aes_key_load = (state_q == StKeyLoad);
  assign aes_start    = start_q;
  assign ctrl_busy    = (state_q != StIdle);
  assign err_flag     = err_ov_q | err_to_q;

  // Command decode, frame progress and reply hand-off to the TX sequencer.
  always_comb begin
    state_d  = state_q;
    tx_load  = 1'b0;
    tx_block = 1'b0;
    tx_byte  = '0;
    unique case (state_q)
      StIdle: begin
        if (rx_data_en) begin
          case (rx_data)
            CMD_KEY: state_d = StRxKey;
            CMD_PT:  state_d = StRxPt;
            CMD_STAT: begin
              tx_load = 1'b1;
              tx_byte = {6'b0, err_ov_q, err_to_q};
              state_d = StTx;
            end
            default: begin
              tx_load = 1'b1;
              tx_byte = RSP_ERR;
              state_d = StTx;
            end
          endcase
        end
      end
      StRxKey, StRxPt: begin
        if (rx_data_en) begin
          if (byte_cnt_q == 4'd15) state_d = (state_q == StRxKey) ? StKeyLoad : StAesStart;
        end else if (to_hit) begin
          state_d = StIdle;
        end
      end
      StKeyLoad: begin
        tx_load = 1'b1;
        tx_byte = RSP_ACK;
        state_d = StTx;
      end
      StAesStart: if (!aes_busy) state_d = StAesWait;
      StAesWait: begin
        if (aes_done) begin
          tx_load  = 1'b1;
          tx_block = 1'b1;
          state_d  = StTx;
        end
      end
      StTx: if (tx_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, data registers, timeout counter and sticky error bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      key_q      <= '0;
      din_q      <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      err_ov_q   <= 1'b0;
      err_to_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_q == StAesStart) && !aes_busy;

      if (state_q == StIdle) byte_cnt_q <= '0;
      else if (in_rx && rx_data_en) byte_cnt_q <= byte_cnt_q + 4'd1;

      if (state_q == StRxKey && rx_data_en) key_q <= {key_q[119:0], rx_data};
      if (state_q == StRxPt && rx_data_en) din_q <= {din_q[119:0], rx_data};

      if (!in_rx || rx_data_en || to_hit) to_cnt_q <= '0;
      else to_cnt_q <= to_cnt_q + TO_W'(1);

      // Set has priority over the status-read clear.
      if (overrun) err_ov_q <= 1'b1;
      else if (stat_clr) err_ov_q <= 1'b0;

      if (to_hit) err_to_q <= 1'b1;
      else if (stat_clr) err_to_q <= 1'b0;
    end
  end

  uart_tx_seq u_tx_seq (
    .clk        (clk),
    .rst        (rst),
    .load       (tx_load),
    .load_block (tx_block),
    .load_byte  (tx_byte),
    .load_data  (aes_dout),
    .done       (tx_done),
    .tx_busy    (tx_busy),
    .tx_data_en (tx_data_en),
    .tx_data    (tx_data)
  );

endmodule

// File: tb/tb_uart_aes_ctrl.sv
// Directed/randomized bench for uart_aes_ctrl with UART and AES stubs.
module tb_uart_aes_ctrl;
  import uart_aes_pkg::*;

  localparam int unsigned TO_CYC = 300;
  localparam logic [127:0] FIPS_CT = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_data_en = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         tx_busy = 1'b0;
  logic         tx_data_en;
  logic [7:0]   tx_data;
  logic [127:0] aes_key, aes_din;
  logic         aes_key_load, aes_start;
  logic         aes_busy = 1'b0;
  logic         aes_done = 1'b0;
  logic [127:0] aes_dout = '0;
  logic         ctrl_busy, err_flag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_aes_ctrl #(
    .RX_TIMEOUT_CYC (TO_CYC),
    .TO_W           (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_en   (rx_data_en),
    .rx_data      (rx_data),
    .tx_busy      (tx_busy),
    .tx_data_en   (tx_data_en),
    .tx_data      (tx_data),
    .aes_key      (aes_key),
    .aes_key_load (aes_key_load),
    .aes_din      (aes_din),
    .aes_start    (aes_start),
    .aes_busy     (aes_busy),
    .aes_done     (aes_done),
    .aes_dout     (aes_dout),
    .ctrl_busy    (ctrl_busy),
    .err_flag     (err_flag)
  );

  // UART transmitter stub: logs each byte at a request rising edge, then busy for a while.
  logic [7:0] tx_log[$];
  logic       en_prev = 1'b0;
  int         busy_dly = 0, busy_left = 0, edge_viol = 0;
  always @(posedge clk) begin
    en_prev <= tx_data_en;
    if (tx_data_en && !en_prev) begin
      if (tx_busy) edge_viol <= edge_viol + 1;
      tx_log.push_back(tx_data);
      busy_dly <= 2;
    end else if (busy_dly > 0) begin
      busy_dly <= busy_dly - 1;
      if (busy_dly == 1) begin
        tx_busy   <= 1'b1;
        busy_left <= int'($urandom_range(3, 8));
      end
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) tx_busy <= 1'b0;
    end
  end

  // AES core stub: 20-cycle latency, returns whatever stub_dout the test set up.
  logic [127:0] stub_dout = '0;
  logic [127:0] stub_din = '0;
  int           aes_lat = 0, start_cnt = 0, keyload_cnt = 0;
  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (aes_lat > 0) begin
      aes_lat <= aes_lat - 1;
      if (aes_lat == 1) begin
        aes_done <= 1'b1;
        aes_dout <= stub_dout;
        aes_busy <= 1'b0;
      end
    end else if (aes_start) begin
      start_cnt <= start_cnt + 1;
      stub_din  <= aes_din;
      aes_busy  <= 1'b1;
      aes_lat   <= 20;
    end
    if (aes_key_load) keyload_cnt <= keyload_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(negedge clk);
    rx_data_en = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_log.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 128'(tx_log.size()), 128'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (ctrl_busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, 128'(ctrl_busy), 128'(0));
  endtask

  task automatic run_encrypt(input logic [127:0] pt, input logic [127:0] ct,
                             input bit inject_overrun);
    int starts0, log0;
    stub_dout = ct;
    starts0   = start_cnt;
    log0      = tx_log.size();
    send_byte(CMD_PT);
    for (int i = 0; i < 15; i++) send_byte(pt[127-8*i -: 8]);
    @(negedge clk);
    rx_data    = pt[7:0];
    rx_data_en = 1'b1;
    @(negedge clk);
    rx_data_en = 1'b0;
    check("start_not_early", 128'(aes_start), 128'(0));
    @(negedge clk);
    check("start_latency2", 128'(aes_start), 128'(1));
    if (inject_overrun) begin
      wait_tx(log0 + 1, "ct_first_byte");
      send_byte(8'h5A);
    end
    wait_tx(log0 + 16, "ct_reply_count");
    for (int i = 0; i < 16; i++) check($sformatf("ct_byte%0d", i),
                                       128'(tx_log[log0+i]), 128'(ct[127-8*i -: 8]));
    wait_idle("enc_idle");
    check("one_aes_start", 128'(start_cnt - starts0), 128'(1));
    check("aes_saw_pt", stub_din, pt);
    check("aes_din_reg", aes_din, pt);
  endtask

  initial begin
    logic [127:0] exp_key, exp_din, pt, ct;
    logic         exp_ov, exp_to;
    logic [7:0]   b;
    int           log0, kl0;

    exp_key = '0;
    exp_din = '0;
    exp_ov  = 1'b0;
    exp_to  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_en", 128'(tx_data_en), 128'(0));
    check("rst_tx_data", 128'(tx_data), 128'(0));
    check("rst_key", aes_key, 128'(0));
    check("rst_din", aes_din, 128'(0));
    check("rst_pulses", 128'({aes_key_load, aes_start}), 128'(0));
    check("rst_flags", 128'({ctrl_busy, err_flag}), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Key load with bytes 0x00..0x0F
    log0 = tx_log.size();
    send_byte(CMD_KEY);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      exp_key = (exp_key << 8) | 128'(i);
    end
    wait_tx(log0 + 1, "key_reply_count");
    check("key_reply", 128'(tx_log[log0]), 128'(RSP_ACK));
    check("key_value", aes_key, exp_key);
    check("key_load_pulses", 128'(keyload_cnt), 128'(1));
    wait_idle("key_idle");

    // Encrypt with random plaintext, FIPS ciphertext from the stub
    pt = {$urandom, $urandom, $urandom, $urandom};
    run_encrypt(pt, FIPS_CT, 1'b0);
    exp_din = pt;
    check("edge_while_idle", 128'(edge_viol), 128'(0));

    // Overrun during ciphertext reply
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = {$urandom, $urandom, $urandom, $urandom};
    run_encrypt(pt, ct, 1'b1);
    exp_din = pt;
    exp_ov  = 1'b1;
    check("ov_err_flag", 128'(err_flag), 128'(exp_ov | exp_to));
    log0 = tx_log.size();
    send_byte(CMD_STAT);
    wait_tx(log0 + 1, "stat_ov_count");
    check("stat_ov", 128'(tx_log[log0]), 128'({6'b0, exp_ov, exp_to}));
    exp_ov = 1'b0;
    wait_idle("stat_ov_idle");
    check("ov_cleared", 128'(err_flag), 128'(0));

    // Timeout mid key frame
    log0 = tx_log.size();
    kl0  = keyload_cnt;
    send_byte(CMD_KEY);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_byte(b);
      exp_key = (exp_key << 8) | 128'(b);
    end
    repeat (TO_CYC / 2) @(negedge clk);
    check("to_not_early", 128'(ctrl_busy), 128'(1));
    repeat (TO_CYC) @(negedge clk);
    exp_to = 1'b1;
    check("to_idle", 128'(ctrl_busy), 128'(0));
    check("to_err_flag", 128'(err_flag), 128'(exp_ov | exp_to));
    check("to_no_keyload", 128'(keyload_cnt - kl0), 128'(0));
    check("to_no_reply", 128'(tx_log.size()), 128'(log0));
    check("to_partial_key", aes_key, exp_key);
    send_byte(CMD_STAT);
    wait_tx(log0 + 1, "stat_to_count");
    check("stat_to", 128'(tx_log[log0]), 128'({6'b0, exp_ov, exp_to}));
    exp_to = 1'b0;
    wait_idle("stat_to_idle");
    check("to_cleared", 128'(err_flag), 128'(0));

    // Unknown commands: 0x00 and one random non-command byte
    for (int j = 0; j < 2; j++) begin
      b = 8'h00;
      if (j == 1) begin
        b = 8'($urandom);
        while (b == CMD_KEY || b == CMD_PT || b == CMD_STAT) b = 8'($urandom);
      end
      log0 = tx_log.size();
      send_byte(b);
      wait_tx(log0 + 1, "unk_count");
      check("unk_reply", 128'(tx_log[log0]), 128'(RSP_ERR));
      wait_idle("unk_idle");
      check("unk_key_kept", aes_key, exp_key);
      check("unk_din_kept", aes_din, exp_din);
    end

    // Reset mid plaintext frame
    send_byte(CMD_PT);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_din", aes_din, 128'(0));
    check("mid_rst_key", aes_key, 128'(0));
    check("mid_rst_flags", 128'({ctrl_busy, err_flag, tx_data_en, aes_start, aes_key_load}),
          128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = {$urandom, $urandom, $urandom, $urandom};
    run_encrypt(pt, ct, 1'b0);
    check("final_edge_viol", 128'(edge_viol), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
